lsu_ctrl: RTL and testbench

Load/store initiator that sits between the core's execute stage and the byte-array data memory, acting as the requesting end of the memory's 11-bit address / 32-bit word port. It accepts one RV32 load or store request at a time and drives the memory port. Byte and halfword stores are performed as read-modify-write. Load data is returned sign- or zero-extended with a one-cycle response pulse; illegal accesses are reported as errors.

---
 rtl/lsu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and a byte-addressed 32-bit data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned H/HU/W accesses instead of executing them.
module lsu_ctrl #(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wrt_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_wr_data;
  logic        r_err;

  logic        w_addr_err;
  logic        w_f3_err;
  logic        w_mis_err;
  logic        w_err;
  logic        w_accept;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge;

  // Decode runs one cycle after accept, on the latched request.
  assign w_addr_err = (r_addr[31:ADDR_W] != '0) || (r_addr > 32'(MEM_BYTES - 4));

  always_comb begin
    w_f3_err = 1'b0;
    if (r_store) begin
      w_f3_err = !(r_funct3 == 3'b000 || r_funct3 == 3'b001 || r_funct3 == 3'b010);
    end else begin
      w_f3_err = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) || (r_funct3 == 3'b111);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis_err = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_funct3 == 3'b010) && (r_addr[1:0] != 2'b00));
`else
  assign w_mis_err = 1'b0;
`endif

  assign w_err    = w_addr_err || w_f3_err || w_mis_err;
  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = {{24{mem_read_data[7]}}, mem_read_data[7:0]};
      3'b001:  w_load_ext = {{16{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b100:  w_load_ext = {24'd0, mem_read_data[7:0]};
      3'b101:  w_load_ext = {16'd0, mem_read_data[15:0]};
      default: w_load_ext = mem_read_data;
    endcase
  end

  // Sub-word stores keep the untouched upper bytes of the word just read.
  assign w_merge = r_funct3[0] ? {mem_read_data[31:16], r_wdata[15:0]}
                               : {mem_read_data[31:8], r_wdata[7:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_store   <= 1'b0;
      r_funct3  <= 3'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_wr_data <= 32'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
          end
        end
        S_DECODE: begin
          r_err   <= w_err;
          r_rdata <= 32'd0;
          if (!w_err && r_store && (r_funct3 == 3'b010)) begin
            r_wr_data <= r_wdata;
          end
        end
        S_READ: begin
          if (r_store) begin
            r_wr_data <= w_merge;
          end else begin
            r_rdata <= w_load_ext;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_wrt_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_err) begin
          w_state_next = S_DONE;
        end else if (r_store && (r_funct3 == 3'b010)) begin
          w_state_next = S_WRITE;
        end else begin
          w_state_next = S_READ;
        end
      end
      S_READ: begin
        w_state_next = r_store ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        // Gated by rst so a reset landing on the write cycle suppresses it.
        mem_wrt_en   = rst;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign resp_err       = resp_valid && r_err;
  assign resp_rdata     = resp_valid ? r_rdata : 32'd0;
  assign mem_addr       = r_addr[ADDR_W-1:0];
  assign mem_write_data = r_wr_data;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised self-checking bench for lsu_ctrl: byte-array memory, transaction-level reference model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [10:0] mem_addr;
  logic        mem_wrt_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(11), .MEM_BYTES(2048)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wrt_en(mem_wrt_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Environment memory driven by the DUT, and the model's own shadow copy.
  logic [7:0] mem     [0:2047];
  logic [7:0] ref_mem [0:2047];

  assign mem_read_data = {mem[mem_addr + 11'd3], mem[mem_addr + 11'd2],
                          mem[mem_addr + 11'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_wrt_en) begin
      for (int i = 0; i < 4; i++) mem[mem_addr + 11'(i)] <= mem_write_data[8*i +: 8];
    end
  end

  int cyc = 0;
  int we_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wrt_en) we_cnt <= we_cnt + 1;
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [10:0] b;
    b = a[10:0];
    return {ref_mem[b + 11'd3], ref_mem[b + 11'd2], ref_mem[b + 11'd1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] env_word(input logic [31:0] a);
    logic [10:0] b;
    b = a[10:0];
    return {mem[b + 11'd3], mem[b + 11'd2], mem[b + 11'd1], mem[b]};
  endfunction

  // Expectations for the transaction in flight.
  bit          txn_active = 1'b0;
  bit          chk_hold = 1'b0;
  bit          checking_on = 1'b0;
  int          acc_cyc = 0;
  int          exp_L = 1;
  bit          exp_err = 1'b0;
  bit          exp_wr = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  logic [31:0] exp_ww = 32'd0;
  logic [10:0] exp_maddr = 11'd0;

  // Reference behaviour: latency in cycles after accept, result data, shadow memory update.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] w;
    bit bad;
    int nb;
    bad = (a > 32'd2044);
    if (st) bad = bad || !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad = bad || (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) bad = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
`endif
    exp_err   = bad;
    exp_rdata = 32'd0;
    exp_wr    = 1'b0;
    exp_ww    = 32'd0;
    exp_maddr = a[10:0];
    if (bad) begin
      exp_L = 1;
    end else if (!st) begin
      exp_L = 2;
      w = ref_word(a);
      case (f3)
        3'd0:    exp_rdata = int'($signed(w[7:0]));
        3'd1:    exp_rdata = int'($signed(w[15:0]));
        3'd4:    exp_rdata = 32'(w[7:0]);
        3'd5:    exp_rdata = 32'(w[15:0]);
        default: exp_rdata = w;
      endcase
    end else begin
      exp_wr = 1'b1;
      nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int i = 0; i < nb; i++) ref_mem[a[10:0] + 11'(i)] = wd[8*i +: 8];
      exp_ww = ref_word(a);
      exp_L  = (f3 == 3'd2) ? 2 : 3;
    end
  endtask

  // Per-cycle comparison against the expected response/write windows.
  always @(negedge clk) begin
    bit rv, we, rdy;
    if (checking_on && rst && !chk_hold) begin
      rv  = txn_active && (cyc == acc_cyc + exp_L + 1);
      we  = txn_active && exp_wr && (cyc == acc_cyc + exp_L);
      rdy = !(txn_active && cyc >= acc_cyc + 1 && cyc <= acc_cyc + exp_L + 1);
      check32("resp_valid", 32'(resp_valid), 32'(rv));
      check32("mem_wrt_en", 32'(mem_wrt_en), 32'(we));
      check32("req_ready", 32'(req_ready), 32'(rdy));
      if (rv) begin
        check32("resp_err", 32'(resp_err), 32'(exp_err));
        check32("resp_rdata", resp_rdata, exp_rdata);
      end
      if (we) begin
        check32("mem_write_data", mem_write_data, exp_ww);
        check32("mem_addr", 32'(mem_addr), 32'(exp_maddr));
      end
    end
  end

  bit          got_err;
  logic [31:0] got_rdata;
  logic [31:0] got_ww;
  int          got_lat;

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    model(st, f3, a, wd);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    acc_cyc    = cyc;
    txn_active = 1'b1;
    got_lat    = -1;
    got_err    = 1'b0;
    got_rdata  = 32'hXXXXXXXX;
    got_ww     = 32'd0;
    while (cyc < acc_cyc + exp_L + 2) begin
      @(negedge clk);
      // Junk requests while busy must be ignored.
      req_valid  = 1'($urandom_range(0, 1));
      req_store  = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (resp_valid && got_lat < 0) begin
        got_lat   = cyc - acc_cyc - 1;
        got_err   = resp_err;
        got_rdata = resp_rdata;
      end
      if (mem_wrt_en) got_ww = mem_write_data;
    end
    req_valid = 1'b0;
    if (a <= 32'd2044) check32("mem_word", env_word(a), ref_word(a));
  endtask

  // SB aborted by a reset pulse in cycle 'stage' after accept (2 = READ, 3 = WRITE).
  task automatic reset_abort(input logic [31:0] a, input int stage);
    int we0;
    for (int i = 0; i < 4; i++) begin
      mem[a[10:0] + 11'(i)]     = 8'h55 + 8'(i * 17);
      ref_mem[a[10:0] + 11'(i)] = 8'h55 + 8'(i * 17);
    end
    we0        = we_cnt;
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = a;
    req_wdata  = 32'h000000EE;
    acc_cyc    = cyc;
    exp_L      = 3;
    exp_wr     = 1'b1;
    exp_err    = 1'b0;
    exp_ww     = {ref_word(a)} & 32'hFFFFFF00 | 32'h000000EE;
    exp_maddr  = a[10:0];
    txn_active = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (cyc < acc_cyc + stage) @(negedge clk);
    chk_hold   = 1'b1;
    txn_active = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    chk_hold = 1'b0;
    check32("abort_ready", 32'(req_ready), 32'd1);
    repeat (4) begin
      @(negedge clk);
      check32("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    check32("abort_no_write", 32'(we_cnt - we0), 32'd0);
    check32("abort_mem", env_word(a), 32'h88776655);
  endtask

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    check32("rst_ready", 32'(req_ready), 32'd1);
    check32("rst_resp_valid", 32'(resp_valid), 32'd0);
    check32("rst_resp_err", 32'(resp_err), 32'd0);
    check32("rst_resp_rdata", resp_rdata, 32'd0);
    check32("rst_mem_addr", 32'(mem_addr), 32'd0);
    check32("rst_mem_wrt_en", 32'(mem_wrt_en), 32'd0);
    check32("rst_mem_write_data", mem_write_data, 32'd0);
    rst = 1'b1;
    checking_on = 1'b1;
    @(negedge clk);

    // Literal pins of the model.
    run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check32("sw_data", got_ww, 32'hDEADBEEF);
    check32("sw_lat", 32'(got_lat), 32'd2);
    run(1'b0, 3'd2, 32'h10, 32'd0);
    check32("lw_data", got_rdata, 32'hDEADBEEF);
    check32("lw_err", 32'(got_err), 32'd0);
    check32("lw_lat", 32'(got_lat), 32'd2);

    {mem[32'h24], mem[32'h23], mem[32'h22], mem[32'h21]} = 32'h11223344;
    {ref_mem[32'h24], ref_mem[32'h23], ref_mem[32'h22], ref_mem[32'h21]} = 32'h11223344;
    run(1'b1, 3'd0, 32'h21, 32'h000000A5);
    check32("sb_merge", got_ww, 32'h112233A5);
    check32("sb_lat", 32'(got_lat), 32'd3);
    run(1'b0, 3'd0, 32'h21, 32'd0);
    check32("lb_data", got_rdata, 32'hFFFFFFA5);
    run(1'b0, 3'd4, 32'h21, 32'd0);
    check32("lbu_data", got_rdata, 32'h000000A5);

    run(1'b1, 3'd1, 32'h40, 32'h00008001);
    check32("sh_lat", 32'(got_lat), 32'd3);
    run(1'b0, 3'd1, 32'h40, 32'd0);
    check32("lh_data", got_rdata, 32'hFFFF8001);
    run(1'b0, 3'd5, 32'h40, 32'd0);
    check32("lhu_data", got_rdata, 32'h00008001);

    run(1'b0, 3'd2, 32'h7FD, 32'd0);
    check32("err_lw_2045", {got_err, 31'(got_lat)}, {1'b1, 31'd1});
    run(1'b1, 3'd2, 32'h800, 32'h12345678);
    check32("err_sw_800", {got_err, 31'(got_lat)}, {1'b1, 31'd1});
    run(1'b0, 3'd3, 32'h0, 32'd0);
    check32("err_load_f3_3", {got_err, 31'(got_lat)}, {1'b1, 31'd1});
    check32("err_rdata", got_rdata, 32'd0);
    run(1'b1, 3'd4, 32'h0, 32'hFFFFFFFF);
    check32("err_sb_f3_4", {got_err, 31'(got_lat)}, {1'b1, 31'd1});

    mem[32'h31] = 8'hCD; mem[32'h32] = 8'h9A;
    ref_mem[32'h31] = 8'hCD; ref_mem[32'h32] = 8'h9A;
    run(1'b0, 3'd1, 32'h31, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check32("lh_mis_err", {got_err, 31'(got_lat)}, {1'b1, 31'd1});
`else
    check32("lh_mis_data", got_rdata, 32'hFFFF9ACD);
    check32("lh_mis_lat", 32'(got_lat), 32'd2);
`endif

    reset_abort(32'h60, 2);
    reset_abort(32'h70, 3);

    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      st  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'd2040 + $urandom_range(0, 8);
      else               a = $urandom_range(0, 2047);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st)                   f3 = 3'($urandom_range(0, 2));
      else                           f3 = 3'($urandom_range(0, 1) * 4 + $urandom_range(0, 1) + (($urandom_range(0, 4) == 0) ? 2 : 0) * (1 - $urandom_range(0, 0)));
      run(st, f3, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
